// File: rtl/sounder_pkg.sv
// Shared types and defaults for the channel-sounder receive sequencer.
package sounder_pkg;

    localparam int CW_DEFAULT      = 16;
    localparam int DEG_MIN_DEFAULT = 2;
    localparam int DEG_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_DUMP = 2'd2
    } state_e;

    // PN sequence length N = 2^degree - 1.
    function automatic logic [31:0] pn_length(input logic [4:0] degree);
        return (32'd1 << degree) - 32'd1;
    endfunction

endpackage

// File: rtl/sounder_chip_counter.sv
// Modulo counter: counts 0..last_i, wraps to 0, clr_i reloads zero.
module sounder_chip_counter
    import sounder_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [CW-1:0] last_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d; otherwise a latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == last_i) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/sounder_seq.sv
// Receive-side sequencer: per-cycle strobes for the sliding correlator,
// one PN period of integration per lag, with Rx FIFO overrun accounting.
module sounder_seq
    import sounder_pkg::*;
#(
    parameter int CW      = CW_DEFAULT,
    parameter int DEG_MIN = DEG_MIN_DEFAULT,
    parameter int DEG_MAX = DEG_MAX_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          transmit_i,
    input  logic          receive_i,
    input  logic [4:0]    degree_i,
    input  logic          rx_full_i,
    input  logic          clr_i,
    output logic          tx_strobe_o,
    output logic          sum_strobe_o,
    output logic          ref_strobe_o,
    output logic          rx_strobe_o,
    output logic          frame_o,
    output logic [CW-1:0] lag_o,
    output logic          busy_o,
    output logic          overrun_o,
    output logic          cfg_err_o
);

    localparam logic [4:0] DEG_LO = 5'(DEG_MIN);
    localparam logic [4:0] DEG_HI = 5'(DEG_MAX);

    state_e        state_d, state_q;
    logic [CW-1:0] n_last_d, n_last_q;
    logic          tx_strobe_d, tx_strobe_q;
    logic          sum_strobe_d, sum_strobe_q;
    logic          ref_strobe_d, ref_strobe_q;
    logic          rx_strobe_d, rx_strobe_q;
    logic          frame_d, frame_q;
    logic [CW-1:0] lag_d, lag_q;
    logic          busy_d, busy_q;
    logic          overrun_d, overrun_q;
    logic          cfg_err_d, cfg_err_q;

    logic          deg_ok;
    logic [CW-1:0] chip_cnt, lag_cnt;
    logic          chip_tc, lag_tc;

    assign deg_ok = (degree_i >= DEG_LO) && (degree_i <= DEG_HI);

    sounder_chip_counter #(.CW(CW)) u_chip_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state_q != ST_SUM),
        .inc_i   (state_q == ST_SUM),
        .last_i  (n_last_q),
        .cnt_o   (chip_cnt),
        .tc_o    (chip_tc)
    );

    // The lag only advances on a DUMP that completes; an abort leaves it for IDLE to clear.
    sounder_chip_counter #(.CW(CW)) u_lag_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state_q == ST_IDLE),
        .inc_i   ((state_q == ST_DUMP) && receive_i),
        .last_i  (n_last_q),
        .cnt_o   (lag_cnt),
        .tc_o    (lag_tc)
    );

    always_comb begin
        state_d     = state_q;
        n_last_d    = n_last_q;
        rx_strobe_d = 1'b0;
        frame_d     = 1'b0;
        lag_d       = lag_q;
        overrun_d   = overrun_q;
        cfg_err_d   = cfg_err_q;

        // Clear is applied first so a same-cycle set below wins.
        if (clr_i) begin
            overrun_d = 1'b0;
            cfg_err_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (receive_i) begin
                    if (deg_ok) begin
                        state_d  = ST_SUM;
                        n_last_d = CW'(pn_length(degree_i) - 32'd1);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_SUM: begin
                if (!receive_i) begin
                    state_d = ST_IDLE;
                end else if (chip_tc) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (!receive_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SUM;
                    lag_d   = lag_cnt;
                    frame_d = lag_tc;
                    if (rx_full_i) begin
                        overrun_d = 1'b1;
                    end else begin
                        rx_strobe_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_strobe_d  = transmit_i;
        sum_strobe_d = (state_d == ST_SUM);
        ref_strobe_d = (state_d == ST_SUM);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            n_last_q     <= '0;
            tx_strobe_q  <= 1'b0;
            sum_strobe_q <= 1'b0;
            ref_strobe_q <= 1'b0;
            rx_strobe_q  <= 1'b0;
            frame_q      <= 1'b0;
            lag_q        <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_last_q     <= n_last_d;
            tx_strobe_q  <= tx_strobe_d;
            sum_strobe_q <= sum_strobe_d;
            ref_strobe_q <= ref_strobe_d;
            rx_strobe_q  <= rx_strobe_d;
            frame_q      <= frame_d;
            lag_q        <= lag_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign tx_strobe_o  = tx_strobe_q;
    assign sum_strobe_o = sum_strobe_q;
    assign ref_strobe_o = ref_strobe_q;
    assign rx_strobe_o  = rx_strobe_q;
    assign frame_o      = frame_q;
    assign lag_o        = lag_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
    assign cfg_err_o    = cfg_err_q;

endmodule
